// File: rtl/sig_seq_monitor.sv
// Watches sig_in for an ordered list of signatures, each within a per-stage cycle budget; SIG_SYNC_EN adds a 2-flop input synchronizer.
// Latency: sig_in change -> accepted after (SIG_SYNC_EN ? 2 : 0) + STABLE cycles; accept -> status/cur_stage 1 cycle later.
// Backpressure: none; pure observer, sticky status held until start (re-arm) or abort.
module sig_seq_monitor #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4,
    parameter int TMO_W  = 24,
    parameter int STABLE = 3
) (
    input  logic                         mclk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [$clog2(STAGES+1)-1:0]  num_stages,
    input  logic [STAGES*WIDTH-1:0]      exp_sig,
    input  logic [TMO_W-1:0]             tmo_limit,
    input  logic [WIDTH-1:0]             sig_in,
    output logic                         busy,
    output logic                         started,
    output logic                         pass,
    output logic                         fail,
    output logic [$clog2(STAGES)-1:0]    cur_stage,
    output logic [WIDTH-1:0]             last_sig
);

    localparam int SW = $clog2(STAGES);
    localparam int RW = $clog2(STABLE + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PASS, S_FAIL} state_t;

    logic [WIDTH-1:0] sample;

`ifdef SIG_SYNC_EN
    logic [WIDTH-1:0] sync1, sync2;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= sig_in;
            sync2 <= sync1;
        end
    end

    assign sample = sync2;
`else
    assign sample = sig_in;
`endif

    // Run-length filter: a value is accepted once, when its run first reaches STABLE.
    logic [WIDTH-1:0] cand;
    logic [RW-1:0]    run, run_nxt;
    logic             same, acc_now, acc_vld;

    always_comb begin
        same    = (sample == cand);
        run_nxt = RW'(1);
        if (same)
            run_nxt = (run == RW'(STABLE)) ? run : run + RW'(1);
        acc_now = (run_nxt == RW'(STABLE)) && (!same || run != RW'(STABLE));
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            cand     <= '0;
            run      <= '0;
            acc_vld  <= 1'b0;
            last_sig <= '0;
        end else begin
            cand    <= sample;
            run     <= run_nxt;
            acc_vld <= acc_now;
            if (acc_now)
                last_sig <= sample;
        end
    end

    state_t               state;
    logic [STAGES*WIDTH-1:0] exp_q;
    logic [TMO_W-1:0]     tmo_q, timer;
    logic [SW-1:0]        last_idx, last_nxt;
    logic [WIDTH-1:0]     cur_exp;
    logic                 match;

    always_comb begin
        last_nxt = '0;
        if (int'(num_stages) > STAGES)
            last_nxt = SW'(STAGES - 1);
        else if (num_stages != '0)
            last_nxt = SW'(int'(num_stages) - 1);
    end

    assign cur_exp = exp_q[int'(cur_stage)*WIDTH +: WIDTH];
    assign match   = acc_vld && (last_sig == cur_exp);

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            started   <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            cur_stage <= '0;
            timer     <= '0;
            exp_q     <= '0;
            tmo_q     <= '0;
            last_idx  <= '0;
        end else if (abort) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            started   <= 1'b0;
            pass      <= 1'b0;
            fail      <= 1'b0;
            cur_stage <= '0;
            timer     <= '0;
        end else begin
            case (state)
                S_IDLE, S_PASS, S_FAIL: begin
                    if (start) begin
                        state     <= S_WAIT;
                        busy      <= 1'b1;
                        started   <= 1'b0;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        cur_stage <= '0;
                        timer     <= '0;
                        exp_q     <= exp_sig;
                        tmo_q     <= tmo_limit;
                        last_idx  <= last_nxt;
                    end
                end
                S_WAIT: begin
                    // A match in the limit cycle takes precedence over the timeout.
                    if (match) begin
                        timer <= '0;
                        if (cur_stage == '0)
                            started <= 1'b1;
                        if (cur_stage == last_idx) begin
                            state <= S_PASS;
                            pass  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cur_stage <= cur_stage + SW'(1);
                        end
                    end else if (tmo_q != '0 && timer == tmo_q) begin
                        state <= S_FAIL;
                        fail  <= 1'b1;
                        busy  <= 1'b0;
                    end else if (timer != '1) begin
                        timer <= timer + TMO_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sig_seq_monitor.sv
// Bench for sig_seq_monitor: vector table, timing corner sequences, randomized run against a reference model.
// Latency: outputs sampled on the falling edge after each rising edge.
// Backpressure: not applicable; stimulus driven on falling edges.
module tb_sig_seq_monitor;
    localparam int STB = 3;
`ifdef SIG_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam logic [63:0] E1 = 64'h0000_0000_AB61_AB60;
    localparam logic [63:0] E2 = 64'h0000_0000_0005_0005;

    logic        mclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [2:0]  num_stages = '0;
    logic [63:0] exp_sig = '0;
    logic [23:0] tmo_limit = '0;
    logic [15:0] sig_in = '0;
    logic        busy, started, pass, fail;
    logic [1:0]  cur_stage;
    logic [15:0] last_sig;

    sig_seq_monitor dut (
        .mclk(mclk), .reset_n(reset_n), .start(start), .abort(abort),
        .num_stages(num_stages), .exp_sig(exp_sig), .tmo_limit(tmo_limit), .sig_in(sig_in),
        .busy(busy), .started(started), .pass(pass), .fail(fail),
        .cur_stage(cur_stage), .last_sig(last_sig)
    );

    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Reference model: outcome of the armed sequence plus a history of filtered samples.
    int          m_mode, m_stage, m_nlast, m_elapsed, n_s;
    bit          m_started, m_pass, m_fail, m_acc;
    logic [15:0] m_last, m_acc_val;
    logic [15:0] m_exp [4];
    logic [23:0] m_tmo;
    logic [15:0] sq [$];
    logic [15:0] fh [$];

    task automatic model_reset();
        m_mode = 0; m_stage = 0; m_nlast = 0; m_elapsed = 0; n_s = 0;
        m_started = 0; m_pass = 0; m_fail = 0; m_acc = 0;
        m_last = '0; m_acc_val = '0; m_tmo = '0;
        for (int k = 0; k < 4; k++) m_exp[k] = '0;
        sq.delete();
        fh.delete();
        for (int k = 0; k < SYNC; k++) sq.push_back(16'h0);
    endtask

    task automatic model_step();
        bit matched, acc;
        logic [15:0] smp;
        matched = m_acc && (m_mode == 1) && (m_acc_val == m_exp[m_stage]);
        if (abort) begin
            m_mode = 0; m_stage = 0; m_elapsed = 0;
            m_started = 0; m_pass = 0; m_fail = 0;
        end else if (m_mode != 1) begin
            if (start) begin
                m_mode = 1; m_stage = 0; m_elapsed = 0;
                m_started = 0; m_pass = 0; m_fail = 0;
                for (int k = 0; k < 4; k++) m_exp[k] = exp_sig[k*16 +: 16];
                m_nlast = (num_stages == 0) ? 0 : ((num_stages > 4) ? 3 : int'(num_stages) - 1);
                m_tmo = tmo_limit;
            end
        end else if (matched) begin
            if (m_stage == 0) m_started = 1;
            if (m_stage == m_nlast) begin
                m_mode = 2; m_pass = 1;
            end else begin
                m_stage++; m_elapsed = 0;
            end
        end else if (m_tmo != 0 && m_elapsed == int'(m_tmo)) begin
            m_mode = 3; m_fail = 1;
        end else if (m_elapsed < 24'hFFFFFF) begin
            m_elapsed++;
        end

        if (SYNC == 0) begin
            smp = sig_in;
        end else begin
            smp = sq.pop_front();
            sq.push_back(sig_in);
        end
        fh.push_back(smp);
        if (fh.size() > STB + 1) void'(fh.pop_front());
        n_s++;
        acc = (n_s >= STB);
        if (acc)
            for (int k = 0; k < STB; k++)
                if (fh[fh.size()-1-k] != smp) acc = 0;
        if (acc && n_s > STB && fh[0] == smp) acc = 0;
        m_acc = acc;
        if (acc) begin
            m_acc_val = smp;
            m_last = smp;
        end
    endtask

    function automatic logic [21:0] got_vec();
        return {busy, started, pass, fail, cur_stage, last_sig};
    endfunction

    task automatic chk(input string name, input logic [21:0] want);
        logic [21:0] got;
        got = got_vec();
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s cyc=%0d busy/started/pass/fail/stage/last got=%b%b%b%b/%0d/%h want=%b%b%b%b/%0d/%h",
                     name, cyc, got[21], got[20], got[19], got[18], got[17:16], got[15:0],
                     want[21], want[20], want[19], want[18], want[17:16], want[15:0]);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        model_step();
        cyc++;
        @(negedge mclk);
        chk("model", {m_mode == 1, m_started, m_pass, m_fail, 2'(m_stage), m_last});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge mclk);
        reset_n = 1'b1;
    endtask

    typedef struct {
        bit          st, ab;
        logic [2:0]  ns;
        logic [63:0] ex;
        logic [23:0] tm;
        logic [15:0] sg;
        int          cy;
        logic [21:0] want;
    } vec_t;

    vec_t tbl [28];

    function automatic vec_t mk(bit st, bit ab, int ns, logic [63:0] ex, int tm, logic [15:0] sg, int cy,
                                bit b, bit s, bit p, bit f, int stg, logic [15:0] last);
        vec_t v;
        v.st = st; v.ab = ab; v.ns = 3'(ns); v.ex = ex; v.tm = 24'(tm); v.sg = sg; v.cy = cy;
        v.want = {b, s, p, f, 2'(stg), last};
        return v;
    endfunction

    function automatic logic [15:0] pick();
        case ($urandom_range(0, 3))
            0: return 16'hAB60;
            1: return 16'hAB61;
            2: return 16'h0005;
            default: return 16'h0000;
        endcase
    endfunction

    // Arm with stage-0 AB60 and run until the stage-1 advance is visible.
    task automatic to_stage1(input int tmo);
        int n;
        abort = 1'b1; sig_in = 16'h0000;
        tick();
        abort = 1'b0;
        repeat (6) tick();
        exp_sig = E1; num_stages = 3'd2; tmo_limit = 24'(tmo);
        start = 1'b1; sig_in = 16'hAB60;
        tick();
        start = 1'b0;
        n = 0;
        while (cur_stage != 2'd1 && n < 20) begin
            tick();
            n++;
        end
        n_cmp++;
        if (cur_stage != 2'd1) begin
            n_err++;
            $display("FAIL reach_stage1 got stage=%0d after %0d cycles want 1", cur_stage, n);
        end
    endtask

    initial begin
        int n, hold;

        tbl[0]  = mk(1,0,2,E1,1000,16'h0000, 1, 1,0,0,0,0,16'h0000);
        tbl[1]  = mk(0,0,2,E1,1000,16'hAB60,10, 1,1,0,0,1,16'hAB60);
        tbl[2]  = mk(0,0,2,E1,1000,16'hAB61,10, 0,1,1,0,1,16'hAB61);
        tbl[3]  = mk(0,1,2,E1,1000,16'hAB61, 1, 0,0,0,0,0,16'hAB61);
        tbl[4]  = mk(1,0,2,E1,1000,16'h0000, 1, 1,0,0,0,0,16'hAB61);
        tbl[5]  = mk(0,0,2,E1,1000,16'h0000, 7, 1,0,0,0,0,16'h0000);
        tbl[6]  = mk(0,0,2,E1,1000,16'hAB60, 2, 1,0,0,0,0,16'h0000);
        tbl[7]  = mk(0,0,2,E1,1000,16'h0000, 7, 1,0,0,0,0,16'h0000);
        tbl[8]  = mk(0,1,2,E1,1000,16'h0000, 1, 0,0,0,0,0,16'h0000);
        tbl[9]  = mk(1,0,2,E1,  20,16'hAB60, 1, 1,0,0,0,0,16'h0000);
        tbl[10] = mk(0,0,2,E1,  20,16'hAB60,40, 0,1,0,1,1,16'hAB60);
        tbl[11] = mk(1,0,2,E2,   0,16'h0005, 1, 1,0,0,0,0,16'hAB60);
        tbl[12] = mk(0,0,2,E2,   0,16'h0005,11, 1,1,0,0,1,16'h0005);
        tbl[13] = mk(0,0,2,E2,   0,16'h0000, 8, 1,1,0,0,1,16'h0000);
        tbl[14] = mk(0,0,2,E2,   0,16'h0005, 8, 0,1,1,0,1,16'h0005);
        tbl[15] = mk(1,0,0,E2,   0,16'h0000, 1, 1,0,0,0,0,16'h0005);
        tbl[16] = mk(0,0,0,E2,   0,16'h0000, 8, 1,0,0,0,0,16'h0000);
        tbl[17] = mk(0,0,0,E2,   0,16'h0005, 8, 0,1,1,0,0,16'h0005);
        tbl[18] = mk(1,0,2,E1,1000,16'hAB60, 1, 1,0,0,0,0,16'h0005);
        tbl[19] = mk(0,0,2,E1,1000,16'hAB60,10, 1,1,0,0,1,16'hAB60);
        tbl[20] = mk(0,1,2,E1,1000,16'hAB61,10, 0,0,0,0,0,16'hAB61);
        tbl[21] = mk(1,0,2,E1,1000,16'h0000, 1, 1,0,0,0,0,16'hAB61);
        tbl[22] = mk(0,0,2,E1,1000,16'hAB60,10, 1,1,0,0,1,16'hAB60);
        tbl[23] = mk(0,0,2,E1,1000,16'hAB61,10, 0,1,1,0,1,16'hAB61);
        tbl[24] = mk(1,1,2,E1,1000,16'hAB61, 1, 0,0,0,0,0,16'hAB61);
        tbl[25] = mk(1,0,2,E1,1000,16'h0000, 1, 1,0,0,0,0,16'hAB61);
        tbl[26] = mk(0,0,4,E2,   5,16'hAB60,10, 1,1,0,0,1,16'hAB60);
        tbl[27] = mk(0,0,4,E2,   5,16'hAB61,10, 0,1,1,0,1,16'hAB61);

        model_reset();
        @(negedge mclk);
        chk("reset_state", 22'h0);
        reset_n = 1'b1;
        repeat (5) tick();

        for (int i = 0; i < 28; i++) begin
            start = tbl[i].st; abort = tbl[i].ab; num_stages = tbl[i].ns;
            exp_sig = tbl[i].ex; tmo_limit = tbl[i].tm; sig_in = tbl[i].sg;
            repeat (tbl[i].cy) tick();
            start = 1'b0; abort = 1'b0;
            chk($sformatf("vec%0d", i), tbl[i].want);
        end

        // Timeout lands tmo_limit+1 edges after the stage-1 advance becomes visible.
        to_stage1(8);
        n = 0;
        while (!fail && n < 50) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n != 9) begin
            n_err++;
            $display("FAIL tmo_exact got %0d cycles want 9", n);
        end

        to_stage1(8);
        repeat (8 - 3 - SYNC) tick();
        sig_in = 16'hAB61;
        repeat (10) tick();
        chk("match_at_limit", {1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 16'hAB61});

        to_stage1(8);
        repeat (8 - 2 - SYNC) tick();
        sig_in = 16'hAB61;
        repeat (10) tick();
        chk("match_after_limit", {1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 16'hAB61});

        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_sig = E2; num_stages = 3'd2; tmo_limit = 24'd0; sig_in = 16'hAB60;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5000) tick();
        chk("no_timeout", {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'hAB60});
        #2 reset_n = 1'b0;
        #1 chk("async_reset", 22'h0);
        model_reset();
        @(negedge mclk);
        reset_n = 1'b1;
        repeat (5) tick();

        hold = 0;
        for (int i = 0; i < 4000; i++) begin
            if (hold == 0) begin
                sig_in = pick();
                hold = $urandom_range(1, 6);
            end
            hold--;
            start = ($urandom_range(0, 29) == 0);
            abort = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int k = 0; k < 4; k++) exp_sig[k*16 +: 16] = pick();
                num_stages = 3'($urandom_range(0, 7));
                tmo_limit = 24'($urandom_range(0, 30));
            end
            if (i % 1500 == 1499) do_reset();
            tick();
        end
        start = 1'b0; abort = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
